// File: rtl/run_detect_pkg.sv
// Shared definitions for the run detector: per-channel FSM states and the
// meaning of each bit of the mode input.
package run_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        HOLD = 2'd3
    } run_state_t;

    localparam int MODE_LEVEL  = 0;  // 0: look for runs of ones, 1: runs of zeros
    localparam int MODE_RETRIG = 1;  // 1: keep producing hits while the run continues

endpackage

// File: rtl/run_detect_ch.sv
// Single-channel run detector: FSM with run counter plus a saturating count
// of hits. Activity and the flush request are decoded by the parent.
module run_detect_ch
    import run_detect_pkg::*;
#(
    parameter int MIN_RUN = 3,
    parameter int EV_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            active,
    input  logic            retrig,
    input  logic            clr,
    output logic            q,
    output logic [EV_W-1:0] ev_cnt
);

    localparam int              CW      = $clog2(MIN_RUN + 1);
    localparam logic [CW-1:0]   RUN_LEN = CW'(MIN_RUN);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [EV_W-1:0] EV_MAX  = '1;

    run_state_t      state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [EV_W-1:0] ev_reg, ev_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cnt_inc    = cnt_reg + ONE;
        if (flush || !active) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next   = ONE;
                    state_next = (RUN_LEN == ONE) ? HIT : RUN;
                end
                RUN: begin
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == RUN_LEN) ? HIT : RUN;
                end
                HIT: begin
                    if (retrig) begin
                        cnt_next   = ONE;
                        state_next = (RUN_LEN == ONE) ? HIT : HOLD;
                    end else begin
                        cnt_next   = '0;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    // Without retrigger the run is parked here until it breaks.
                    if (retrig) begin
                        cnt_next   = cnt_inc;
                        state_next = (cnt_inc == RUN_LEN) ? HIT : HOLD;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ev_next = ev_reg;
        if (clr) begin
            ev_next = '0;
        end else if (state_next == HIT && ev_reg != EV_MAX) begin
            ev_next = ev_reg + EV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ev_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ev_reg    <= ev_next;
        end
    end

    assign q      = (state_reg == HIT);
    assign ev_cnt = ev_reg;

endmodule

// File: rtl/run_detect.sv
// Multi-channel run detector: N_CH independent channels sharing one mode.
// A change of active level flushes every channel back to IDLE.
module run_detect
    import run_detect_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MIN_RUN = 3,
    parameter int EV_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      i,
    input  logic [1:0]           mode,
    input  logic                 clr,
    output logic [N_CH-1:0]      q,
    output logic [N_CH*EV_W-1:0] ev_cnt
);

    logic level_reg;
    logic flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_reg <= 1'b0;
        end else begin
            level_reg <= mode[MODE_LEVEL];
        end
    end

    assign flush = (mode[MODE_LEVEL] != level_reg);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            // A sample is active when it matches the selected level.
            run_detect_ch #(
                .MIN_RUN(MIN_RUN),
                .EV_W   (EV_W)
            ) u_ch (
                .clk   (clk),
                .reset (reset),
                .flush (flush),
                .active(i[gi] ^ mode[MODE_LEVEL]),
                .retrig(mode[MODE_RETRIG]),
                .clr   (clr),
                .q     (q[gi]),
                .ev_cnt(ev_cnt[gi*EV_W +: EV_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_run_detect.sv
// Directed bench for run_detect (N_CH=4, MIN_RUN=3, EV_W=8) with a queue of
// expected q / ev_cnt values checked one cycle after each driven edge.
module tb_run_detect;

    localparam int N_CH = 4;
    localparam int EV_W = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_CH-1:0]      i;
    logic [1:0]           mode;
    logic                 clr;
    logic [N_CH-1:0]      q;
    logic [N_CH*EV_W-1:0] ev_cnt;

    typedef struct {
        logic [N_CH-1:0]      q;
        logic [N_CH*EV_W-1:0] ev;
        int                   id;
    } exp_t;

    exp_t sb[$];
    int   ev_model [N_CH];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    run_detect #(.N_CH(N_CH), .MIN_RUN(3), .EV_W(EV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .i     (i),
        .mode  (mode),
        .clr   (clr),
        .q     (q),
        .ev_cnt(ev_cnt)
    );

    always #5 clk = ~clk;

    // Drive one edge worth of inputs, push the expected post-edge outputs,
    // then pop and compare just after the edge.
    task automatic step(input logic [N_CH-1:0] iv, input logic [1:0] md,
                        input logic cl, input logic rs, input logic [N_CH-1:0] eq);
        exp_t e;
        exp_t got;
        i = iv; mode = md; clr = cl; reset = rs;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (rs || cl) ev_model[ch] = 0;
            else if (eq[ch] && ev_model[ch] < 255) ev_model[ch] = ev_model[ch] + 1;
        end
        e.q  = eq;
        e.ev = '0;
        for (int ch = 0; ch < N_CH; ch++) e.ev[ch*EV_W +: EV_W] = EV_W'(ev_model[ch]);
        e.id = step_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_cmp++;
        assert (q === got.q) else begin
            n_fail++;
            $error("FAIL q step %0d observed %b expected %b", got.id, q, got.q);
        end
        n_cmp++;
        assert (ev_cnt === got.ev) else begin
            n_fail++;
            $error("FAIL ev_cnt step %0d observed %h expected %h", got.id, ev_cnt, got.ev);
        end
        $display("step %0d i=%b mode=%b clr=%b reset=%b q=%b ev_cnt=%h",
                 got.id, iv, md, cl, rs, q, ev_cnt);
        step_id++;
    endtask

    initial begin
        for (int ch = 0; ch < N_CH; ch++) ev_model[ch] = 0;
        i = '0; mode = 2'b00; clr = 1'b0; reset = 1'b1;

        // Reset state
        step(4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000);
        step(4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // Single pulse, no retrigger: 5 active samples on ch0
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0001);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // Retrigger: 9 active samples, hits after 3, 6, 9
        for (int n = 1; n <= 9; n++)
            step(4'b0001, 2'b10, 1'b0, 1'b0, (n % 3 == 0) ? 4'b0001 : 4'b0000);
        step(4'b0000, 2'b10, 1'b0, 1'b0, 4'b0000);

        // Gap of one inactive sample restarts detection on ch1
        step(4'b0010, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0010, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0010, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0010, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0010, 2'b00, 1'b0, 1'b0, 4'b0010);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // Run of zeros on ch2 (others held inactive at 1)
        step(4'b1111, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b1011, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b1011, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b1011, 2'b01, 1'b0, 1'b0, 4'b0100);
        step(4'b1111, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // Simultaneous hits on ch0 and ch1 each count once
        step(4'b0011, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0011, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0011, 2'b00, 1'b0, 1'b0, 4'b0011);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // Reset mid-run (with clr and activity) discards the partial run
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b1, 1'b1, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0001);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // Level change mid-run flushes all channels regardless of i
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0001, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b01, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b01, 1'b0, 1'b0, 4'b1111);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

        // 300 retriggered hits on ch3 saturate its counter
        for (int n = 1; n <= 900; n++)
            step(4'b1000, 2'b10, 1'b0, 1'b0, (n % 3 == 0) ? 4'b1000 : 4'b0000);
        n_cmp++;
        assert (ev_cnt[3*EV_W +: EV_W] === 8'd255) else begin
            n_fail++;
            $error("FAIL ev_sat observed %0d expected 255", ev_cnt[3*EV_W +: EV_W]);
        end

        // clr on an edge entering HIT zeroes the count, q still pulses
        step(4'b1000, 2'b10, 1'b0, 1'b0, 4'b0000);
        step(4'b1000, 2'b10, 1'b0, 1'b0, 4'b0000);
        step(4'b1000, 2'b10, 1'b1, 1'b0, 4'b1000);
        step(4'b1000, 2'b10, 1'b0, 1'b0, 4'b0000);
        step(4'b1000, 2'b10, 1'b0, 1'b0, 4'b0000);
        step(4'b1000, 2'b10, 1'b0, 1'b0, 4'b1000);
        step(4'b0000, 2'b10, 1'b0, 1'b0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
